icache: RTL and testbench

Direct-mapped instruction cache sitting directly upstream of the instruction fetch queue. It accepts word-aligned fetch addresses from the PC logic and returns the 32-bit instruction on a one-cycle valid pulse that drives the fetch queue's `icache_have_input` / `icache_instr_input`. Misses are refilled from the memory controller over its 8-bit, one-byte-per-beat port. Branch mispredicts abort an outstanding miss through a flush input.

---
 rtl/icache.sv | 140 ++++++++++++++
 tb/tb_icache.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache in front of the fetch queue.
// Misses refill byte-by-byte from the memory controller; flush aborts a refill.
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        pc_valid_in,
    input  logic [31:0] pc_in,
    output logic        icache_ready_out,
    input  logic        if_full_in,
    input  logic        flush_in,
    output logic        icache_valid_out,
    output logic [31:0] icache_instr_out,
    output logic [31:0] icache_pc_out,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_byte_valid_in,
    input  logic [7:0]  mem_byte_in
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    // The response cycle after a refill is carried by the registered output
    // pulse, so the FSM is back in IDLE (and accepting) while it is shown.
    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [29:0]       req_word_q, req_word_d;
    logic [31:0]       asm_q, asm_d;
    logic [LINES-1:0]  line_valid_q, line_valid_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_q, pc_d;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit, accept, fill_we;
    logic                  unused_pc_bits;

    assign unused_pc_bits   = ^pc_in[1:0];
    assign req_idx          = pc_in[INDEX_BITS+1:2];
    assign req_tag          = pc_in[31:INDEX_BITS+2];
    assign fill_idx         = req_word_q[INDEX_BITS-1:0];
    assign hit              = line_valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign icache_ready_out = (state_q == IDLE) && !if_full_in && !flush_in;
    assign accept           = pc_valid_in && icache_ready_out && rdy_in;

    // Beat never exceeds 3, so base + beat is just the beat in the low bits.
    assign mem_req_out      = (state_q == FETCH);
    assign mem_addr_out     = mem_req_out ? {req_word_q, beat_q} : 32'd0;
    assign icache_valid_out = valid_q;
    assign icache_instr_out = instr_q;
    assign icache_pc_out    = pc_q;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        req_word_d   = req_word_q;
        asm_d        = asm_q;
        line_valid_d = line_valid_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        fill_we      = 1'b0;
        if (rdy_in) begin
            valid_d = 1'b0;
            if (flush_in) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            req_word_d = pc_in[31:2];
                            if (hit) begin
                                valid_d = 1'b1;
                                instr_d = data_mem[req_idx];
                                pc_d    = {pc_in[31:2], 2'b00};
                            end else begin
                                state_d = FETCH;
                                beat_d  = 2'd0;
                                asm_d   = 32'd0;
                            end
                        end
                    end
                    FETCH: begin
                        if (mem_byte_valid_in) begin
                            asm_d[{beat_q, 3'b000} +: 8] = mem_byte_in;
                            beat_d = beat_q + 2'd1;
                            if (beat_q == 2'd3) begin
                                fill_we                = 1'b1;
                                line_valid_d[fill_idx] = 1'b1;
                                state_d                = IDLE;
                                valid_d                = 1'b1;
                                instr_d                = asm_d;
                                pc_d                   = {req_word_q, 2'b00};
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            beat_q       <= 2'd0;
            req_word_q   <= 30'd0;
            asm_q        <= 32'd0;
            line_valid_q <= '0;
            valid_q      <= 1'b0;
            instr_q      <= 32'd0;
            pc_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            req_word_q   <= req_word_d;
            asm_q        <= asm_d;
            line_valid_q <= line_valid_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
        end
    end

    // Tag/data arrays need no reset: the valid bits gate every lookup.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= req_word_q[29:INDEX_BITS];
            data_mem[fill_idx] <= asm_d;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Randomized and directed bench for icache against a transaction-level cache model.
module tb_icache;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        pc_valid_in = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        icache_ready_out;
    logic        if_full_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        icache_valid_out;
    logic [31:0] icache_instr_out;
    logic [31:0] icache_pc_out;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_byte_valid_in = 1'b0;
    logic [7:0]  mem_byte_in = 8'd0;

    icache #(.INDEX_BITS(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .pc_valid_in(pc_valid_in), .pc_in(pc_in),
        .icache_ready_out(icache_ready_out), .if_full_in(if_full_in),
        .flush_in(flush_in), .icache_valid_out(icache_valid_out),
        .icache_instr_out(icache_instr_out), .icache_pc_out(icache_pc_out),
        .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
        .mem_byte_valid_in(mem_byte_valid_in), .mem_byte_in(mem_byte_in)
    );

    always #5 clk_in = ~clk_in;

    // Instruction memory image: byte address [9:0] selects the byte.
    logic [7:0] mem [1024];

    // Model: which lines are resident, plus the outstanding refill and pulse.
    bit          c_valid [64];
    logic [23:0] c_tag   [64];
    bit          m_busy = 0;
    int          m_cnt = 0;
    logic [31:0] m_pc = 0;
    bit          e_valid = 0;
    logic [31:0] e_instr = 0, e_pc = 0;

    int total = 0, bad = 0;
    int cyc = 0, acc_cyc = 0, pulse_cyc = 0, n_acc = 0;
    int run = 0, max_run = 0;
    int beat_mode = 1;        // 0 random, 1 every cycle, 2 never
    bit junk_beats = 0;
    bit accepted = 0, req_prev = 0, req_seen = 0;
    logic [31:0] first_addr = 0, last_instr = 0, last_pc = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0;
        p = p | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: drive the memory side, compare outputs, advance the model.
    task automatic step();
        logic v;
        logic [31:0] p;
        v = 1'b0;
        mem_byte_in = 8'($urandom);
        if (mem_req_out) begin
            v = (beat_mode == 1) || (beat_mode == 0 && $urandom_range(0, 3) != 0);
            mem_byte_in = mem[mem_addr_out[9:0]];
        end else if (junk_beats) begin
            v = 1'b1;
        end
        mem_byte_valid_in = v;
        #1;
        chk("ready", icache_ready_out, {31'd0, !m_busy && !if_full_in && !flush_in});
        chk("valid", icache_valid_out, {31'd0, e_valid});
        if (e_valid) begin
            chk("instr", icache_instr_out, e_instr);
            chk("pc", icache_pc_out, e_pc);
        end
        chk("mem_req", mem_req_out, {31'd0, m_busy});
        if (m_busy) chk("mem_addr", mem_addr_out, m_pc + 32'(m_cnt));
        if (icache_valid_out) begin
            pulse_cyc  = cyc;
            last_instr = icache_instr_out;
            last_pc    = icache_pc_out;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (mem_req_out && !req_prev) first_addr = mem_addr_out;
        if (mem_req_out) req_seen = 1;
        req_prev = mem_req_out;

        accepted = 0;
        if (rdy_in) begin
            if (flush_in) begin
                m_busy  = 0;
                e_valid = 0;
            end else if (m_busy) begin
                e_valid = 0;
                if (mem_byte_valid_in) begin
                    m_cnt++;
                    if (m_cnt == 4) begin
                        c_valid[m_pc[7:2]] = 1;
                        c_tag[m_pc[7:2]]   = m_pc[31:8];
                        m_busy  = 0;
                        e_valid = 1;
                        e_instr = word_at(m_pc);
                        e_pc    = m_pc;
                    end
                end
            end else if (pc_valid_in && !if_full_in) begin
                accepted = 1;
                n_acc++;
                acc_cyc = cyc;
                p = {pc_in[31:2], 2'b00};
                if (c_valid[p[7:2]] && c_tag[p[7:2]] == p[31:8]) begin
                    e_valid = 1;
                    e_instr = word_at(p);
                    e_pc    = p;
                end else begin
                    e_valid = 0;
                    m_busy  = 1;
                    m_cnt   = 0;
                    m_pc    = p;
                end
            end else begin
                e_valid = 0;
            end
        end
        cyc++;
        @(negedge clk_in);
    endtask

    task automatic fetch(input logic [31:0] a);
        int n;
        n = 0;
        pc_valid_in = 1'b1;
        pc_in = a;
        do begin
            step();
            n++;
        end while (!accepted && n < 200);
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
        pc_valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_busy || e_valid) && n < 200) begin
            step();
            n++;
        end
        if (m_busy || e_valid) chk("drain_timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        for (int i = 0; i < 64; i++) begin c_valid[i] = 0; c_tag[i] = 0; end

        repeat (2) @(posedge clk_in);
        #2;
        chk("rst_valid", icache_valid_out, 0);
        chk("rst_instr", icache_instr_out, 0);
        chk("rst_pc", icache_pc_out, 0);
        chk("rst_mem_req", mem_req_out, 0);
        chk("rst_mem_addr", mem_addr_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        @(negedge clk_in);

        // First miss assembles the little-endian word.
        beat_mode = 1;
        fetch(32'h0); drain();
        chk("first_word", last_instr, 32'h0010_0513);
        chk("first_pc", last_pc, 32'h0);

        fetch(32'h4); drain();
        fetch(32'h8); drain();
        req_seen = 0;
        fetch(32'h0); drain();
        chk("hit_latency", 32'(pulse_cyc - acc_cyc), 32'd1);
        chk("hit_no_req", {31'd0, req_seen}, 32'd0);

        max_run = 0;
        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        drain();
        chk("back_to_back", 32'(max_run), 32'd3);

        // Same index, different tag.
        fetch(32'h100); drain();
        chk("conflict_addr", first_addr, 32'h100);
        fetch(32'h0); drain();
        chk("refetch_addr", first_addr, 32'h0);
        chk("refetch_word", last_instr, 32'h0010_0513);

        // Flush after two beats, then stray beats.
        fetch(32'h20);
        step(); step();
        chk("flush_cnt", 32'(m_cnt), 32'd2);
        flush_in = 1'b1; step(); flush_in = 1'b0;
        junk_beats = 1; repeat (3) step(); junk_beats = 0;
        first_addr = 32'hFFFF_FFFF;
        fetch(32'h20); drain();
        chk("flush_refetch_addr", first_addr, 32'h20);
        chk("flush_refetch_word", last_instr, word_at(32'h20));

        // Fetch queue full blocks acceptance only.
        pc_in = 32'h4; pc_valid_in = 1'b1; if_full_in = 1'b1;
        n0 = n_acc;
        repeat (3) step();
        chk("full_blocks", 32'(n_acc - n0), 32'd0);
        if_full_in = 1'b0;
        step();
        chk("full_release_accept", {31'd0, accepted}, 32'd1);
        pc_valid_in = 1'b0;
        drain();
        chk("full_release_latency", 32'(pulse_cyc - acc_cyc), 32'd1);

        // Global stall mid-refill.
        fetch(32'h40);
        step();
        rdy_in = 1'b0;
        repeat (3) begin
            step();
            chk("stall_addr", mem_addr_out, 32'h41);
        end
        rdy_in = 1'b1;
        drain();
        chk("stall_pc", last_pc, 32'h40);

        // Random traffic.
        beat_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pc_valid_in || accepted) begin
                pc_valid_in = ($urandom_range(0, 3) != 0);
                pc_in = rand_pc();
            end
            flush_in   = ($urandom_range(0, 19) == 0);
            if_full_in = ($urandom_range(0, 6) == 0);
            rdy_in     = ($urandom_range(0, 9) != 0);
            junk_beats = ($urandom_range(0, 9) == 0);
            step();
        end
        pc_valid_in = 0; flush_in = 0; if_full_in = 0; rdy_in = 1; junk_beats = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
